// File: rtl/draw_pkg.sv
// Shared constants, state encoding and coordinate helpers for the square-drawing scheduler.
package draw_pkg;

    localparam int NUM_REQ = 4;
    localparam int SQ      = 4;
    localparam int X_W     = 8;
    localparam int Y_W     = 7;
    localparam int C_W     = 3;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Coordinates wrap at their field width; nothing is clipped to the visible screen.
    function automatic logic [X_W-1:0] add_x(input logic [X_W-1:0] base, input logic [1:0] off);
        return base + X_W'(off);
    endfunction

    function automatic logic [Y_W-1:0] add_y(input logic [Y_W-1:0] base, input logic [1:0] off);
        return base + Y_W'(off);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible requester after last_grant, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = draw_pkg::NUM_REQ,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic               valid
);
    import draw_pkg::*;

    logic [NUM_REQ-1:0] eligible;
    logic [IDX_W-1:0]   idx;

    assign eligible = req & ~mask;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IDX_W'((int'(last_grant) + 1 + i) % NUM_REQ);
            if (!valid && eligible[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/draw_scheduler.sv
// Arbitrates several requesters onto one 4x4 square drawer that streams pixels to a VGA adapter.
module draw_scheduler #(
    parameter int NUM_REQ = draw_pkg::NUM_REQ,
    parameter int SQ      = draw_pkg::SQ
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req,
    input  logic [draw_pkg::X_W*NUM_REQ-1:0]   req_x,
    input  logic [draw_pkg::Y_W*NUM_REQ-1:0]   req_y,
    input  logic [draw_pkg::C_W*NUM_REQ-1:0]   req_colour,
    output logic [NUM_REQ-1:0]                 done,
    output logic                               busy,
    output logic [draw_pkg::X_W-1:0]           vga_x,
    output logic [draw_pkg::Y_W-1:0]           vga_y,
    output logic [draw_pkg::C_W-1:0]           vga_colour,
    output logic                               plot
);
    import draw_pkg::*;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(SQ * SQ - 1);

    state_t               state, state_nx;
    logic [CNT_W-1:0]     cnt, cnt_nx;
    logic [X_W-1:0]       base_x, base_x_nx;
    logic [Y_W-1:0]       base_y, base_y_nx;
    logic [C_W-1:0]       colour, colour_nx;
    logic [IDX_W-1:0]     last_grant, last_grant_nx;
    logic [NUM_REQ-1:0]   mask, mask_nx;

    logic [NUM_REQ-1:0]   grant;
    logic                 grant_valid;
    logic [IDX_W-1:0]     grant_idx;
    logic [NUM_REQ-1:0]   served;

    logic [X_W-1:0]       src_x   [NUM_REQ];
    logic [Y_W-1:0]       src_y   [NUM_REQ];
    logic [C_W-1:0]       src_col [NUM_REQ];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req        (req),
        .mask       (mask),
        .last_grant (last_grant),
        .grant      (grant),
        .valid      (grant_valid)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            src_x[i]   = req_x[i*X_W +: X_W];
            src_y[i]   = req_y[i*Y_W +: Y_W];
            src_col[i] = req_colour[i*C_W +: C_W];
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
    end

    // last_grant doubles as the identity of the square in flight.
    assign served = {{(NUM_REQ-1){1'b0}}, 1'b1} << last_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            base_x     <= '0;
            base_y     <= '0;
            colour     <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
            mask       <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            base_x     <= base_x_nx;
            base_y     <= base_y_nx;
            colour     <= colour_nx;
            last_grant <= last_grant_nx;
            mask       <= mask_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        base_x_nx     = base_x;
        base_y_nx     = base_y;
        colour_nx     = colour;
        last_grant_nx = last_grant;
        mask_nx       = '0;
        done          = '0;
        busy          = 1'b0;
        plot          = 1'b0;
        vga_x         = '0;
        vga_y         = '0;
        vga_colour    = '0;

        case (state)
            S_IDLE: begin
                if (grant_valid) begin
                    state_nx      = S_DRAW;
                    cnt_nx        = '0;
                    base_x_nx     = src_x[grant_idx];
                    base_y_nx     = src_y[grant_idx];
                    colour_nx     = src_col[grant_idx];
                    last_grant_nx = grant_idx;
                end
            end
            S_DRAW: begin
                busy       = 1'b1;
                plot       = 1'b1;
                vga_x      = add_x(base_x, cnt[1:0]);
                vga_y      = add_y(base_y, cnt[3:2]);
                vga_colour = colour;
                if (cnt == LAST_PIX) begin
                    state_nx = S_DONE;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                busy     = 1'b1;
                done     = served;
                // Keep the just-served requester out of the very next arbitration.
                mask_nx  = served;
                state_nx = S_IDLE;
            end
            default: begin
                busy     = 1'b1;
                state_nx = S_IDLE;
            end
        endcase

        if (reset) begin
            done       = '0;
            busy       = 1'b0;
            plot       = 1'b0;
            vga_x      = '0;
            vga_y      = '0;
            vga_colour = '0;
        end
    end

endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: vector table, corner-case sequences and a queue-based reference model.
module tb_draw_scheduler;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_x;
    logic [7*N-1:0] req_y;
    logic [3*N-1:0] req_colour;
    logic [N-1:0]   done;
    logic           busy;
    logic [7:0]     vga_x;
    logic [6:0]     vga_y;
    logic [2:0]     vga_colour;
    logic           plot;

    typedef struct packed {
        logic         busy;
        logic         plot;
        logic [7:0]   x;
        logic [6:0]   y;
        logic [2:0]   col;
        logic [N-1:0] dn;
    } rec_t;

    typedef struct {
        logic         rst;
        logic [N-1:0] rq;
        int           who;
        logic [7:0]   x;
        logic [6:0]   y;
        logic [2:0]   col;
        rec_t         exp;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    vec_t tbl[$];
    rec_t mq[$];
    rec_t mcur;
    int   mlg;
    int   mmask;
    rec_t obs;

    always #5 clk = ~clk;

    draw_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
        .done       (done),
        .busy       (busy),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot)
    );

    assign obs = {busy, plot, vga_x, vga_y, vga_colour, done};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic rec_t pix(input logic [7:0] bx, input logic [6:0] by, input logic [2:0] col, input int c);
        rec_t r;
        r.busy = 1'b1;
        r.plot = 1'b1;
        r.x    = bx + 8'(c % 4);
        r.y    = by + 7'(c / 4);
        r.col  = col;
        r.dn   = '0;
        return r;
    endfunction

    function automatic rec_t fin(input int g);
        rec_t r = '0;
        r.busy = 1'b1;
        r.dn   = N'(1 << g);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_rec(input string name, input rec_t act, input rec_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got busy=%b plot=%b x=%0d y=%0d col=%0d done=%b, expected busy=%b plot=%b x=%0d y=%0d col=%0d done=%b",
                     name, act.busy, act.plot, act.x, act.y, act.col, act.dn,
                     exp.busy, exp.plot, exp.x, exp.y, exp.col, exp.dn);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        req_x[8*i +: 8]      = x;
        req_y[7*i +: 7]      = y;
        req_colour[3*i +: 3] = c;
    endtask

    task automatic add_row(input logic rst, input logic [N-1:0] rq, input int g,
                           input logic [7:0] x, input logic [6:0] y, input logic [2:0] col, input rec_t exp);
        vec_t v;
        v.rst = rst; v.rq = rq; v.who = g; v.x = x; v.y = y; v.col = col; v.exp = exp;
        tbl.push_back(v);
    endtask

    // Request held through the draw, dropped once done is seen: 16 pixels, done, then idle.
    task automatic add_square(input int g, input logic [7:0] x, input logic [6:0] y, input logic [2:0] col);
        for (int c = 0; c < 16; c++) add_row(1'b0, N'(1 << g), g, x, y, col, pix(x, y, col, c));
        add_row(1'b0, N'(1 << g), g, x, y, col, fin(g));
        add_row(1'b0, '0, g, x, y, col, '0);
    endtask

    task automatic wait_done(output logic [N-1:0] d);
        int n = 0;
        d = '0;
        while (n < 100) begin
            tick;
            n++;
            if (done != '0) begin
                d = done;
                break;
            end
        end
    endtask

    // Reference model: a granted square becomes a queue of 16 pixel records plus a done record.
    task automatic model_edge;
        if (reset) begin
            mq.delete();
            mcur  = '0;
            mlg   = N - 1;
            mmask = -1;
        end else if (mcur.busy) begin
            if (mcur.dn != '0) begin
                for (int i = 0; i < N; i++) if (mcur.dn[i]) mmask = i;
                mcur = '0;
            end else begin
                mcur = mq.pop_front();
            end
        end else begin
            int g = -1;
            for (int k = 1; k <= N; k++) begin
                int i = (mlg + k) % N;
                if (g < 0 && req[i] && i != mmask) g = i;
            end
            mmask = -1;
            if (g >= 0) begin
                for (int c = 0; c < 16; c++)
                    mq.push_back(pix(req_x[8*g +: 8], req_y[7*g +: 7], req_colour[3*g +: 3], c));
                mq.push_back(fin(g));
                mlg  = g;
                mcur = mq.pop_front();
            end else begin
                mcur = '0;
            end
        end
    endtask

    task automatic seq_contention;
        int order[$];
        int when[$];
        int cyc   = 0;
        int plots = 0;
        reset = 1'b1; req = '0; tick; reset = 1'b0;
        for (int i = 0; i < N; i++) set_src(i, 8'(20 * i), 7'(10 * i), 3'(i + 1));
        req = '1;
        while (order.size() < 5 && cyc < 200) begin
            tick;
            cyc++;
            if (plot) plots++;
            if (done != '0) begin
                check("rr_onehot", $countones(done), 1);
                for (int i = 0; i < N; i++) if (done[i]) order.push_back(i);
                when.push_back(cyc);
            end
        end
        check("rr_count", order.size(), 5);
        for (int k = 0; k < order.size(); k++) check($sformatf("rr_order%0d", k), order[k], k % N);
        for (int k = 1; k < when.size(); k++) check("rr_gap", when[k] - when[k-1], 18);
        if (when.size() > 0) check("rr_first_done", when[0], 17);
        check("rr_plots", plots, 80);
        req = '0;
    endtask

    task automatic seq_input_change;
        reset = 1'b1; req = '0; tick; reset = 1'b0;
        set_src(1, 8'd40, 7'd50, 3'b101);
        req = 4'b0010;
        tick;
        for (int c = 0; c < 16; c++) begin
            check_rec($sformatf("chg_pix%0d", c), obs, pix(8'd40, 7'd50, 3'b101, c));
            if (c == 5) begin
                set_src(1, 8'd99, 7'd9, 3'b010);
                req = '0;
            end
            tick;
        end
        check_rec("chg_done", obs, fin(1));
        tick;
        check_rec("chg_idle", obs, '0);
    endtask

    task automatic seq_abort;
        int          seen = 0;
        logic [N-1:0] d;
        reset = 1'b1; req = '0; tick; reset = 1'b0;
        set_src(2, 8'd70, 7'd30, 3'b011);
        req = 4'b0100;
        tick;
        for (int c = 0; c < 7; c++) tick;
        check_rec("abort_c7", obs, pix(8'd70, 7'd30, 3'b011, 7));
        reset = 1'b1;
        tick;
        check_rec("abort_out", obs, '0);
        reset = 1'b0;
        req   = '0;
        for (int n = 0; n < 20; n++) begin
            tick;
            if (done != '0 || plot) seen++;
        end
        check("abort_no_done", seen, 0);
        set_src(3, 8'd1, 7'd2, 3'b110);
        req = 4'b1100;
        wait_done(d);
        check("abort_first", d, 4'b0100);
        wait_done(d);
        check("abort_second", d, 4'b1000);
        req = '0;
        tick; tick;
    endtask

    task automatic seq_sole;
        int   starts[$];
        int   dones[$];
        logic prev = 1'b0;
        int   cyc  = 0;
        reset = 1'b1; req = '0; tick; reset = 1'b0;
        set_src(3, 8'd5, 7'd5, 3'b001);
        req = 4'b1000;
        while (starts.size() < 3 && cyc < 200) begin
            tick;
            cyc++;
            if (plot && !prev) starts.push_back(cyc);
            if (done != '0) dones.push_back(cyc);
            prev = plot;
        end
        check("sole_count", starts.size(), 3);
        if (starts.size() > 0) check("sole_first", starts[0], 1);
        for (int k = 1; k < starts.size(); k++) check("sole_period", starts[k] - starts[k-1], 19);
        if (dones.size() > 0 && starts.size() > 1) check("sole_gap", starts[1] - dones[0], 3);
        req = '0;
    endtask

    task automatic run_random(input int cycles);
        reset = 1'b1;
        req   = '0;
        for (int n = 0; n < cycles; n++) begin
            if (n > 0) begin
                reset      = ($urandom_range(0, 149) == 0);
                req        = req ^ N'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
                req_x      = $urandom;
                req_y      = 28'($urandom);
                req_colour = 12'($urandom);
            end
            model_edge();
            tick;
            check_rec("rand", obs, mcur);
        end
    endtask

    initial begin
        reset = 1'b1; req = '0; req_x = '0; req_y = '0; req_colour = '0;

        add_row(1'b1, '0, 0, 8'd0, 7'd0, 3'd0, '0);
        add_square(0, 8'd10, 7'd20, 3'b100);
        add_row(1'b0, '0, 0, 8'd0, 7'd0, 3'd0, '0);
        add_square(1, 8'd254, 7'd126, 3'b111);
        add_square(2, 8'd159, 7'd119, 3'b010);
        add_square(3, 8'd0, 7'd5, 3'b001);

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst;
            req   = tbl[i].rq;
            set_src(tbl[i].who, tbl[i].x, tbl[i].y, tbl[i].col);
            tick;
            check_rec($sformatf("vec%0d", i), obs, tbl[i].exp);
        end

        seq_contention();
        seq_input_change();
        seq_abort();
        seq_sole();
        run_random(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
